dmem_arbiter: RTL and testbench

Two-port arbiter and sequencer for the 50 x 8-bit data memory. Lets the processor load/store path (port 0) and a debug/DMA loader (port 1) share the single-ported memory. Round-robin arbitration and a registered command stage drive the memory's `mem_write`, `mem_read`, `address` and `data_in` inputs. Read data from the memory's registered `data_out` is steered back to the owning port with a valid strobe.

---
 rtl/dmem_pkg.sv | 27 ++
 rtl/dmem_arbiter_if.sv | 56 +++++
 rtl/dmem_arbiter_rr_arb2.sv | 41 ++++
 rtl/dmem_arbiter.sv | 129 ++++++++++++
 tb/tb_dmem_arbiter.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_pkg.sv
// -----------------------------------------------------------------------------
// dmem_pkg
// Shared definitions for the data-memory arbiter: memory geometry, requester
// port identifiers and the response-tag record carried alongside each command.
// No ports (package).
// -----------------------------------------------------------------------------
package dmem_pkg;

    localparam int DEPTH  = 50;
    localparam int ADDR_W = 6;
    localparam int DATA_W = 8;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_DMA = 1'b1;

    // Response tag travels two stages so it lines up with the memory's
    // registered read data.
    localparam int TAG_W = 4;

    typedef struct packed {
        logic valid;
        logic port;
        logic is_read;
        logic err;
    } rsp_tag_t;

endpackage

// File: rtl/dmem_arbiter_if.sv
// -----------------------------------------------------------------------------
// dmem_arbiter_if
// Bundle of both requester ports and the memory command/read-data path.
//   pN_req/we/addr/wdata : request payload, held until granted
//   pN_gnt               : accept this cycle
//   pN_rvalid/rdata/err  : completion strobes, two cycles after accept
//   mem_*                : registered command to the single-ported memory,
//                          mem_rdata is the memory's registered data_out
// Modports: slave = arbiter side, master = requesters + memory side.
// -----------------------------------------------------------------------------
interface dmem_arbiter_if;
    import dmem_pkg::*;

    logic              p0_req;
    logic              p0_we;
    logic [ADDR_W-1:0] p0_addr;
    logic [DATA_W-1:0] p0_wdata;
    logic              p0_gnt;
    logic              p0_rvalid;
    logic [DATA_W-1:0] p0_rdata;
    logic              p0_err;

    logic              p1_req;
    logic              p1_we;
    logic [ADDR_W-1:0] p1_addr;
    logic [DATA_W-1:0] p1_wdata;
    logic              p1_gnt;
    logic              p1_rvalid;
    logic [DATA_W-1:0] p1_rdata;
    logic              p1_err;

    logic              mem_write;
    logic              mem_read;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  p0_req, p0_we, p0_addr, p0_wdata,
        input  p1_req, p1_we, p1_addr, p1_wdata,
        input  mem_rdata,
        output p0_gnt, p0_rvalid, p0_rdata, p0_err,
        output p1_gnt, p1_rvalid, p1_rdata, p1_err,
        output mem_write, mem_read, mem_addr, mem_wdata
    );

    modport master (
        output p0_req, p0_we, p0_addr, p0_wdata,
        output p1_req, p1_we, p1_addr, p1_wdata,
        output mem_rdata,
        input  p0_gnt, p0_rvalid, p0_rdata, p0_err,
        input  p1_gnt, p1_rvalid, p1_rdata, p1_err,
        input  mem_write, mem_read, mem_addr, mem_wdata
    );

endinterface

// File: rtl/dmem_arbiter_rr_arb2.sv
// -----------------------------------------------------------------------------
// rr_arb2
// Two-requester round-robin grant.
//   clk, reset : clock, synchronous active-high reset
//   req[1:0]   : request per port (bit index = port id)
//   accept     : a grant was taken this cycle; moves the priority pointer
//   gnt[1:0]   : one-hot (or zero) grant, combinational
// last_gnt resets to the DMA port so the CPU port wins the first tie.
// -----------------------------------------------------------------------------
module rr_arb2
    import dmem_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       accept,
    output logic [1:0] gnt
);

    logic last_gnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            last_gnt <= PORT_DMA;
        end else if (accept) begin
            last_gnt <= gnt[1];
        end
    end

    always_comb begin
        gnt = 2'b00;
        if (!reset) begin
            if (req[0] && req[1]) begin
                gnt = (last_gnt == PORT_DMA) ? 2'b01 : 2'b10;
            end else begin
                gnt = req;
            end
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
// Shares the single-ported 50 x 8 data memory between the CPU load/store port
// (port 0) and the debug/DMA loader (port 1). Round-robin grant, one registered
// command stage, and a two-stage response tag that steers the memory's
// registered read data back to the owning port.
//   clk, reset : clock, synchronous active-high reset
//   bus        : dmem_arbiter_if.slave (both requester ports + memory side)
// Optional build macro DMEM_ARB_BOUNDS_CHECK_EN: accepted transfers with
// address >= DEPTH issue no memory command and complete with pN_err (reads
// also return rvalid with zero data). Without it addresses pass through and
// pN_err stays 0.
// Widths on the interface come from dmem_pkg; keep the parameters at their
// defaults.
// -----------------------------------------------------------------------------
module dmem_arbiter #(
    parameter int DEPTH  = dmem_pkg::DEPTH,
    parameter int ADDR_W = dmem_pkg::ADDR_W,
    parameter int DATA_W = dmem_pkg::DATA_W
) (
    input  logic           clk,
    input  logic           reset,
    dmem_arbiter_if.slave  bus
);
    import dmem_pkg::*;

`ifdef DMEM_ARB_BOUNDS_CHECK_EN
    localparam bit BOUNDS_EN = 1'b1;
`else
    localparam bit BOUNDS_EN = 1'b0;
`endif

    logic [1:0]        req;
    logic [1:0]        gnt;
    logic              accept;
    logic              sel;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              oob;
    rsp_tag_t          tag_s1;
    rsp_tag_t          tag_s2;

    assign req = {bus.p1_req, bus.p0_req};

    rr_arb2 u_rr_arb2 (
        .clk    (clk),
        .reset  (reset),
        .req    (req),
        .accept (accept),
        .gnt    (gnt)
    );

    assign accept     = |gnt;
    assign sel        = gnt[1];
    assign bus.p0_gnt = gnt[0];
    assign bus.p1_gnt = gnt[1];

    always_comb begin
        if (sel == PORT_DMA) begin
            sel_we    = bus.p1_we;
            sel_addr  = bus.p1_addr;
            sel_wdata = bus.p1_wdata;
        end else begin
            sel_we    = bus.p0_we;
            sel_addr  = bus.p0_addr;
            sel_wdata = bus.p0_wdata;
        end
    end

    assign oob = BOUNDS_EN && (sel_addr >= ADDR_W'(DEPTH));

    // Command stage. Out-of-range transfers leave addr/wdata untouched so the
    // memory pins only move for commands it actually executes.
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.mem_write <= 1'b0;
            bus.mem_read  <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
        end else begin
            bus.mem_write <= accept && sel_we && !oob;
            bus.mem_read  <= accept && !sel_we && !oob;
            if (accept && !oob) begin
                bus.mem_addr  <= sel_addr;
                bus.mem_wdata <= sel_wdata;
            end
        end
    end

    // Stage 1 sits with the command, stage 2 with mem_rdata.
    always_ff @(posedge clk) begin
        if (reset) begin
            tag_s1 <= '0;
            tag_s2 <= '0;
        end else begin
            tag_s1.valid   <= accept;
            tag_s1.port    <= sel;
            tag_s1.is_read <= !sel_we;
            tag_s1.err     <= oob;
            tag_s2         <= tag_s1;
        end
    end

    always_comb begin
        bus.p0_rvalid = 1'b0;
        bus.p0_rdata  = '0;
        bus.p0_err    = 1'b0;
        bus.p1_rvalid = 1'b0;
        bus.p1_rdata  = '0;
        bus.p1_err    = 1'b0;
        if (!reset && tag_s2.valid) begin
            if (tag_s2.port == PORT_CPU) begin
                bus.p0_rvalid = tag_s2.is_read;
                bus.p0_err    = tag_s2.err;
                if (tag_s2.is_read && !tag_s2.err) begin
                    bus.p0_rdata = bus.mem_rdata;
                end
            end else begin
                bus.p1_rvalid = tag_s2.is_read;
                bus.p1_err    = tag_s2.err;
                if (tag_s2.is_read && !tag_s2.err) begin
                    bus.p1_rdata = bus.mem_rdata;
                end
            end
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dmem_arbiter
// Drives both requester ports from stimulus queues, models the external memory,
// and checks grants, memory commands and completions against a reference model
// of the arbitration and memory-ordering rules.
// Build with DMEM_ARB_BOUNDS_CHECK_EN defined to match an RTL built with it.
// -----------------------------------------------------------------------------
module tb_dmem_arbiter;
    import dmem_pkg::*;

`ifdef DMEM_ARB_BOUNDS_CHECK_EN
    localparam bit BCHK = 1'b1;
`else
    localparam bit BCHK = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    dmem_arbiter_if bus ();

    dmem_arbiter dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        bit       we;
        bit [5:0] addr;
        bit [7:0] wdata;
        int       gap;
    } stim_t;

    typedef struct {
        int       due;
        bit       port;
        bit       rd;
        bit       err;
        bit [7:0] data;
    } rsp_t;

    typedef struct {
        int       due;
        bit       wr;
        bit       rd;
        bit [5:0] addr;
        bit [7:0] wdata;
    } cmd_t;

    stim_t sq0[$];
    stim_t sq1[$];
    rsp_t  rq[$];
    cmd_t  cq[$];

    int checks = 0;
    int passed = 0;
    int cyc = 0;

    bit [7:0]   ref_mem [64];
    bit         model_last;
    logic [7:0] tbmem [64];

    always @(posedge clk) cyc <= cyc + 1;

    // External memory: registered read, write and read ordered by cycle.
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 64; i++) tbmem[i] <= 8'(i * 37 + 5);
        end else if (bus.mem_write) begin
            tbmem[bus.mem_addr] <= bus.mem_wdata;
        end
        if (bus.mem_read) bus.mem_rdata <= tbmem[bus.mem_addr];
    end

    // Reference model: decides who should be granted and what that transfer
    // must produce, then queues the expectations.
    initial begin
        logic [1:0] eg;
        bit         p;
        bit         we;
        bit [5:0]   a;
        bit [7:0]   d;
        bit         bad;
        forever begin
            @(negedge clk);
            eg = 2'b00;
            if (reset) begin
                model_last = 1'b1;
                for (int i = 0; i < 64; i++) ref_mem[i] = 8'(i * 37 + 5);
                while (rq.size() > 0 && rq[$].due > cyc) void'(rq.pop_back());
            end else if (bus.p0_req && bus.p1_req) begin
                eg = model_last ? 2'b01 : 2'b10;
            end else begin
                eg = {bus.p1_req, bus.p0_req};
            end
            checks++;
            if ({bus.p1_gnt, bus.p0_gnt} === eg) passed++;
            else $display("FAIL gnt cyc=%0d got=%b exp=%b", cyc, {bus.p1_gnt, bus.p0_gnt}, eg);
            if (eg != 2'b00) begin
                p  = eg[1];
                we = p ? bus.p1_we : bus.p0_we;
                a  = p ? bus.p1_addr : bus.p0_addr;
                d  = p ? bus.p1_wdata : bus.p0_wdata;
                model_last = p;
                bad = BCHK && (a >= 6'd50);
                cq.push_back('{due: cyc + 1, wr: we && !bad, rd: !we && !bad, addr: a, wdata: d});
                if (!we || bad)
                    rq.push_back('{due: cyc + 2, port: p, rd: !we, err: bad,
                                   data: (bad || we) ? 8'h00 : ref_mem[a]});
                if (we && !bad) ref_mem[a] = d;
            end
        end
    end

    // Monitor: compares what the DUT presents against queued expectations.
    initial begin
        rsp_t     e;
        cmd_t     c;
        bit [19:0] exp_r;
        bit [19:0] got_r;
        bit        ok;
        forever begin
            @(negedge clk);
            exp_r = '0;
            if (rq.size() > 0 && rq[0].due <= cyc) begin
                e = rq.pop_front();
                if (e.port) exp_r[9:0]   = {e.rd, e.err, e.rd ? e.data : 8'h00};
                else        exp_r[19:10] = {e.rd, e.err, e.rd ? e.data : 8'h00};
            end
            got_r = {bus.p0_rvalid, bus.p0_err, bus.p0_rdata,
                     bus.p1_rvalid, bus.p1_err, bus.p1_rdata};
            checks++;
            if (got_r === exp_r) passed++;
            else $display("FAIL rsp cyc=%0d got=%h exp=%h (p0 v,e,d | p1 v,e,d)", cyc, got_r, exp_r);

            c = '{due: 0, wr: 1'b0, rd: 1'b0, addr: 6'd0, wdata: 8'd0};
            if (cq.size() > 0 && cq[0].due <= cyc) c = cq.pop_front();
            ok = (bus.mem_write === c.wr) && (bus.mem_read === c.rd);
            if (c.wr || c.rd) ok = ok && (bus.mem_addr === c.addr);
            if (c.wr) ok = ok && (bus.mem_wdata === c.wdata);
            checks++;
            if (ok) passed++;
            else $display("FAIL cmd cyc=%0d got w=%b r=%b a=%0d d=%h exp w=%b r=%b a=%0d d=%h",
                          cyc, bus.mem_write, bus.mem_read, bus.mem_addr, bus.mem_wdata,
                          c.wr, c.rd, c.addr, c.wdata);
        end
    end

    // Driver: holds each request until the DUT takes it.
    initial begin
        logic [1:0] g;
        stim_t      s;
        bus.p0_req = 1'b0; bus.p0_we = 1'b0; bus.p0_addr = '0; bus.p0_wdata = '0;
        bus.p1_req = 1'b0; bus.p1_we = 1'b0; bus.p1_addr = '0; bus.p1_wdata = '0;
        forever begin
            @(negedge clk);
            g = {bus.p1_gnt & bus.p1_req, bus.p0_gnt & bus.p0_req};
            @(posedge clk);
            #1;
            if (g[0]) bus.p0_req = 1'b0;
            if (!bus.p0_req && sq0.size() > 0) begin
                if (sq0[0].gap > 0) sq0[0].gap = sq0[0].gap - 1;
                else begin
                    s = sq0.pop_front();
                    bus.p0_req = 1'b1; bus.p0_we = s.we; bus.p0_addr = s.addr; bus.p0_wdata = s.wdata;
                end
            end
            if (g[1]) bus.p1_req = 1'b0;
            if (!bus.p1_req && sq1.size() > 0) begin
                if (sq1[0].gap > 0) sq1[0].gap = sq1[0].gap - 1;
                else begin
                    s = sq1.pop_front();
                    bus.p1_req = 1'b1; bus.p1_we = s.we; bus.p1_addr = s.addr; bus.p1_wdata = s.wdata;
                end
            end
        end
    end

    task automatic push(input bit p, input bit we, input bit [5:0] a, input bit [7:0] d, input int gap);
        stim_t s;
        s = '{we: we, addr: a, wdata: d, gap: gap};
        if (p) sq1.push_back(s);
        else   sq0.push_back(s);
    endtask

    task automatic wait_idle(input string name, input int limit);
        bit done;
        done = 1'b0;
        for (int i = 0; i < limit && !done; i++) begin
            @(posedge clk);
            if (sq0.size() == 0 && sq1.size() == 0 && !bus.p0_req && !bus.p1_req &&
                rq.size() == 0 && cq.size() == 0) done = 1'b1;
        end
        if (!done) begin
            checks++;
            $display("FAIL timeout %s got=busy exp=idle", name);
        end
    endtask

    initial begin
        bit seen;
        // Both ports requesting throughout reset; port 0 must win first after.
        push(0, 1'b0, 6'd3, 8'h00, 0);
        push(1, 1'b0, 6'd4, 8'h00, 0);
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        wait_idle("reset_first", 50);

        push(0, 1'b1, 6'd7, 8'hA5, 0);
        push(0, 1'b0, 6'd7, 8'h00, 0);
        wait_idle("single_wr_rd", 50);

        for (int i = 0; i < 3; i++) begin
            push(0, 1'b0, 6'(i + 10), 8'h00, 0);
            push(1, 1'b0, 6'(i + 20), 8'h00, 0);
        end
        wait_idle("contention", 50);

        push(1, 1'b1, 6'd49, 8'h3C, 0);
        push(0, 1'b0, 6'd49, 8'h00, 1);
        wait_idle("cross_wr_rd", 50);

        push(1, 1'b0, 6'd50, 8'h00, 0);
        push(0, 1'b1, 6'd55, 8'h77, 0);
        push(1, 1'b1, 6'd63, 8'h11, 0);
        push(0, 1'b0, 6'd55, 8'h00, 0);
        wait_idle("bounds", 50);

        // Reset in the cycle after a read is accepted: its completion is lost.
        push(0, 1'b0, 6'd10, 8'h00, 0);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (bus.p0_gnt && bus.p0_req) seen = 1'b1;
        end
        checks++;
        if (seen) passed++;
        else $display("FAIL midreset_accept got=0 exp=1");
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        wait_idle("mid_reset", 50);

        for (int i = 0; i < 300; i++) begin
            push(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 99) < 85) ? 6'($urandom_range(0, 49)) : 6'($urandom_range(50, 63)),
                 8'($urandom), ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0);
        end
        wait_idle("random", 3000);

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
